// File: rtl/rca_64.sv
// rca_64: 64-bit ripple-carry adder with combinational outputs and a
// registered copy of sum, carry-out and signed overflow.
// The carry ripples through 16 four-bit stages of one-bit full-adder cells.
// No lookahead or carry-select logic is used anywhere in the chain.
module rca_64 (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Cin,
    output logic [63:0] SUM,
    output logic        Cout,
    output logic        OVF,
    output logic [63:0] SUM_R,
    output logic        COUT_R,
    output logic        OVF_R
);

    // One four-bit ripple stage.
    // The return value is packed as {carry out, carry into bit 3, sum[3:0]}.
    // The carry into bit 3 is needed only by the top stage, where it is c_63.
    function automatic logic [5:0] ripple4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic       c;
        logic       c3;
        logic [3:0] s;
        c  = cin;
        c3 = 1'b0;
        s  = '0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                c3 = c;
            end
            s[k] = a[k] ^ b[k] ^ c;
            c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
        end
        return {c, c3, s};
    endfunction

    logic [63:0] w_sum;
    logic        w_carry;
    logic        w_c63;
    logic [5:0]  w_stage;

    // Ripple the carry through 16 chained four-bit stages, starting from Cin.
    always_comb begin
        w_sum   = '0;
        w_carry = Cin;
        w_c63   = 1'b0;
        w_stage = '0;
        for (int st = 0; st < 16; st++) begin
            w_stage           = ripple4(A[st*4 +: 4], B[st*4 +: 4], w_carry);
            w_sum[st*4 +: 4]  = w_stage[3:0];
            w_c63             = w_stage[4];
            w_carry           = w_stage[5];
        end
    end

    // Signed overflow occurs when the carry into the sign bit (c_63)
    // differs from the carry out of the sign bit (c_64).
    assign SUM  = w_sum;
    assign Cout = w_carry;
    assign OVF  = w_carry ^ w_c63;

    logic [63:0] r_sum;
    logic        r_cout;
    logic        r_ovf;

    // Capture the combinational result every cycle.
    // Reset has priority over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry;
            r_ovf  <= w_carry ^ w_c63;
        end
    end

    assign SUM_R  = r_sum;
    assign COUT_R = r_cout;
    assign OVF_R  = r_ovf;

endmodule

// File: tb/tb_rca_64.sv
// tb_rca_64: directed and random checks for rca_64.
// Expected registered results go into a scoreboard queue when the inputs
// are driven. They are popped and compared one edge later.
module tb_rca_64;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] A;
    logic [63:0] B;
    logic        Cin;
    logic [63:0] SUM;
    logic        Cout;
    logic        OVF;
    logic [63:0] SUM_R;
    logic        COUT_R;
    logic        OVF_R;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t sb_q[$];
    res_t last_reg;
    int   n_vec = 0;
    int   n_err = 0;

    rca_64 dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .SUM    (SUM),
        .Cout   (Cout),
        .OVF    (OVF),
        .SUM_R  (SUM_R),
        .COUT_R (COUT_R),
        .OVF_R  (OVF_R)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a 65-bit add, with overflow derived from the operand and result signs.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [64:0] t;
        res_t        r;
        t      = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        r.sum  = t[63:0];
        r.cout = t[64];
        r.ovf  = (a[63] == b[63]) && (t[63] != a[63]);
        return r;
    endfunction

    task automatic check_comb(input string tag, input res_t e);
        chk({tag, ".SUM"},  SUM,           e.sum);
        chk({tag, ".Cout"}, {63'd0, Cout}, {63'd0, e.cout});
        chk({tag, ".OVF"},  {63'd0, OVF},  {63'd0, e.ovf});
    endtask

    task automatic check_reg(input string tag);
        res_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s.sb: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".SUM_R"},  SUM_R,           e.sum);
            chk({tag, ".COUT_R"}, {63'd0, COUT_R}, {63'd0, e.cout});
            chk({tag, ".OVF_R"},  {63'd0, OVF_R},  {63'd0, e.ovf});
            last_reg = e;
        end
    endtask

    // Inputs change at the negedge. The registers must still show the
    // previous value until the next rising edge.
    task automatic apply(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input res_t e);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        #1;
        check_comb(tag, e);
        chk({tag, ".hold"}, SUM_R, last_reg.sum);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_reg(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t        e;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;

        rst = 1'b1;
        A   = 64'd5;
        B   = 64'd7;
        Cin = 1'b1;

        // Hold reset for two edges. The combinational path keeps tracking the inputs.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.SUM_R",  SUM_R,           64'd0);
        chk("rst.COUT_R", {63'd0, COUT_R}, 64'd0);
        chk("rst.OVF_R",  {63'd0, OVF_R},  64'd0);
        chk("rst.SUM",    SUM,             64'd13);
        last_reg = '0;

        // Release reset with a full carry ripple.
        rst = 1'b0;
        apply("wrap1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, '{64'd0, 1'b1, 1'b0});

        apply("dec1", 64'd1234567890123456, 64'd9876543210123456, 1'b0,
              '{64'd11111111100246912, 1'b0, 1'b0});
        apply("dec2", 64'd10000000000000000, 64'd9999999999999999, 1'b1,
              '{64'd20000000000000000, 1'b0, 1'b0});
        apply("cin_wrap", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, '{64'd0, 1'b1, 1'b0});
        apply("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
              '{64'h8000_0000_0000_0000, 1'b0, 1'b1});
        apply("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              '{64'd0, 1'b1, 1'b1});
        apply("alt", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1,
              '{64'd0, 1'b1, 1'b0});

        for (int i = 0; i < 8; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(1, 0));
            e  = model(ra, rb, rc);
            apply($sformatf("rnd%0d", i), ra, rb, rc, e);
        end

        // Reassert reset mid-operation. The registers clear on the next edge,
        // while the combinational outputs keep following A/B/Cin.
        @(negedge clk);
        rst = 1'b1;
        A   = 64'h7FFF_FFFF_FFFF_FFFF;
        B   = 64'd1;
        Cin = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2.SUM_R",  SUM_R,           64'd0);
        chk("rst2.COUT_R", {63'd0, COUT_R}, 64'd0);
        chk("rst2.OVF_R",  {63'd0, OVF_R},  64'd0);
        check_comb("rst2", '{64'h8000_0000_0000_0000, 1'b0, 1'b1});
        last_reg = '0;

        // Capture resumes on the first edge with reset low.
        rst = 1'b0;
        apply("resume", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
